// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
//
// This unit resolves BEQ/BNE branches in the ID stage. It stalls the front end
// while a source operand is still being produced further down the pipe. The
// stall lasts one cycle for an EX ALU result or a MEM load. It lasts two
// cycles for an EX load. The unit then redirects the PC and flushes IF/ID if
// the branch is taken.
//
// Optional build macro:
//   BRANCH_STATS_EN  adds saturating resolved/taken branch counters.
//
// Ports:
//   clk           sole clock, rising edge
//   rst_n         synchronous active-low reset
//   id_valid      ID-stage instruction valid (low while waiting = kill)
//   id_opcode     ID-stage opcode (BEQ=6'h04, BNE=6'h05)
//   id_rs, id_rt  branch source registers
//   cmp_equal     ID-stage 32-bit operand equality
//   ex_reg_write  EX-stage instruction writes a register
//   ex_mem_read   EX-stage instruction is a load
//   ex_rd         EX-stage destination register
//   mem_mem_read  MEM-stage instruction is a load
//   mem_rd        MEM-stage destination register
//   stall         hold PC and IF/ID
//   pc_src        select branch target for next PC
//   if_flush      zero the IF/ID register
//   br_count      resolved branches, saturating (BRANCH_STATS_EN only)
//   taken_count   taken branches, saturating (BRANCH_STATS_EN only)
// ----------------------------------------------------------------------------
module branch_resolve_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        cmp_equal,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_rd,
    output logic        stall,
    output logic        pc_src,
`ifdef BRANCH_STATS_EN
    output logic        if_flush,
    output logic [15:0] br_count,
    output logic [15:0] taken_count
`else
    output logic        if_flush
`endif
);

    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESOLVE
    } state_t;

    state_t state, state_next;

    logic is_branch;
    logic taken;
    logic ex_match;
    logic mem_match;
    logic resolve;

    // Register 0 is hard-wired, so a write to it can never be a real hazard.
    always_comb begin
        is_branch = id_valid && ((id_opcode == OP_BEQ) || (id_opcode == OP_BNE));
        taken     = (id_opcode == OP_BNE) ? !cmp_equal : cmp_equal;
        ex_match  = (ex_rd  != 5'd0) && ((ex_rd  == id_rs) || (ex_rd  == id_rt));
        mem_match = (mem_rd != 5'd0) && ((mem_rd == id_rs) || (mem_rd == id_rt));
    end

    // Outputs are gated by rst_n combinationally. This keeps them quiet for
    // the whole time reset is held, and not only after the first reset edge.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        pc_src     = 1'b0;
        if_flush   = 1'b0;
        resolve    = 1'b0;

        if (!rst_n) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (is_branch) begin
                        if (ex_mem_read && ex_match) begin
                            stall      = 1'b1;
                            state_next = WAIT;
                        end else if ((ex_reg_write && ex_match) ||
                                     (mem_mem_read && mem_match)) begin
                            stall      = 1'b1;
                            state_next = RESOLVE;
                        end else begin
                            pc_src   = taken;
                            if_flush = taken;
                            resolve  = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (!id_valid) begin
                        state_next = IDLE;
                    end else begin
                        stall      = 1'b1;
                        state_next = RESOLVE;
                    end
                end
                RESOLVE: begin
                    state_next = IDLE;
                    if (id_valid) begin
                        pc_src   = taken;
                        if_flush = taken;
                        resolve  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count    <= '0;
            taken_count <= '0;
        end else if (resolve) begin
            if (br_count != '1) begin
                br_count <= br_count + 16'd1;
            end
            if (taken && (taken_count != '1)) begin
                taken_count <= taken_count + 16'd1;
            end
        end
    end
`else
    logic unused_resolve;
    assign unused_resolve = resolve;
`endif

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-003 SHALL have port id_valid  input  1  ID-stage instruction valid.
REQ-004 SHALL have port id_opcode  input  6  ID-stage opcode; BEQ=6'h04, BNE=6'h05.
REQ-005 SHALL have ports id_rs, id_rt  input  5 each  branch source registers.
REQ-006 SHALL have port cmp_equal  input  1  32-bit ID-stage operand equality result from the branch comparator.
REQ-007 SHALL have ports ex_reg_write, ex_mem_read  input  1 each  EX-stage writes register / is load.
REQ-008 SHALL have port ex_rd  input  5  EX-stage destination register.
REQ-009 SHALL have ports mem_mem_read  input  1 and mem_rd  input  5  MEM-stage load and destination.
REQ-010 SHALL have port stall  output  1  hold PC and IF/ID.
REQ-011 SHALL have port pc_src  output  1  select branch target for next PC.
REQ-012 SHALL have port if_flush  output  1  zero the IF/ID register.
REQ-013 SHALL have ports br_count, taken_count  output  16 each  statistics; present only under BRANCH_STATS_EN.

Function
REQ-014 SHALL treat a cycle as a branch cycle when id_valid=1 and id_opcode is BEQ or BNE; all other opcodes produce no output activity.
REQ-015 SHALL define taken = cmp_equal for BEQ and = !cmp_equal for BNE.
REQ-016 SHALL define match(r) = (r!=0) and (r==id_rs or r==id_rt); register 0 never causes a hazard.
REQ-017 SHALL compute hazard depth N: N=2 if ex_mem_read and match(ex_rd); else N=1 if (ex_reg_write and match(ex_rd)) or (mem_mem_read and match(mem_rd)); else N=0.
REQ-018 SHALL implement FSM states IDLE, WAIT, RESOLVE.
REQ-019 IDLE, branch cycle, N=0: stall=0, pc_src=taken, if_flush=taken in the same cycle (zero-latency); remain IDLE.
REQ-020 IDLE, branch cycle, N=1: stall=1, pc_src=0, if_flush=0; next state RESOLVE.
REQ-021 IDLE, branch cycle, N=2: stall=1, pc_src=0, if_flush=0; next state WAIT.
REQ-022 WAIT: stall=1, pc_src=0, if_flush=0; next state RESOLVE.
REQ-023 RESOLVE: stall=0, pc_src=taken, if_flush=taken, hazard inputs ignored; next state IDLE.
REQ-024 In WAIT or RESOLVE with id_valid=0 (upstream kill): stall=0, pc_src=0, if_flush=0, next state IDLE, no statistics update.
REQ-025 Hazard inputs SHALL be evaluated only in IDLE; changes during WAIT/RESOLVE have no effect.
REQ-026 Total stall cycles per branch SHALL equal N exactly; pc_src and if_flush SHALL be asserted only in the resolving cycle and only when taken.
REQ-027 A branch resolving in cycle t SHALL allow a new branch evaluation in IDLE at t+1 (back-to-back branches, no bubble).

Reset
REQ-028 rst_n=0 at a rising edge SHALL force state IDLE from any state, including mid-WAIT.
REQ-029 While rst_n=0: stall=0, pc_src=0, if_flush=0; br_count=0, taken_count=0 when present.
REQ-030 First branch evaluation SHALL occur on the first edge with rst_n=1.

Configuration
REQ-031 Macro BRANCH_STATS_EN defined: br_count and taken_count ports exist; in each resolving cycle br_count increments by 1 and taken_count increments by 1 if taken; both saturate at 16'hFFFF.
REQ-032 Macro BRANCH_STATS_EN undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-033 BEQ rs=3 rt=4, no hazards, cmp_equal=1 -> same cycle pc_src=1, if_flush=1, stall=0; cmp_equal=0 -> all 0.
REQ-034 BNE rs=5, ex_reg_write=1 ex_rd=5, cmp_equal=0 -> cycle0 stall=1; cycle1 stall=0, pc_src=1, if_flush=1.
REQ-035 BEQ rt=7, ex_mem_read=1 ex_rd=7, cmp_equal=1 -> stall=1 for 2 cycles, pc_src=if_flush=1 in cycle 2, then IDLE.
REQ-036 BEQ rs=0, ex_mem_read=1 ex_rd=0 -> no stall; resolves in cycle 0.
REQ-037 N=2 hazard, rst_n=0 asserted during WAIT -> next cycle IDLE, all outputs 0, counters 0; id_valid=0 during WAIT instead -> abort, no pc_src.
REQ-038 With BRANCH_STATS_EN: 3 branches (2 taken) -> br_count=3, taken_count=2; preload counters at 16'hFFFF via 65535 resolved branches -> further branches hold 16'hFFFF.
